// File: rtl/flow_math_pkg.sv
// flow_math_pkg: lane widths, lane types and the per-lane product helper
// shared by the flow_mult datapath.
package flow_math_pkg;

    localparam int DATA_W = 16;
    localparam int MULT_W = 10;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic        [MULT_W-1:0] mult_t;

    // Low DATA_W bits of a product are the same whether the operands are
    // treated as signed or unsigned, so a plain DATA_W-wide multiply suffices.
    function automatic data_t mul_lane(input data_t d, input mult_t m);
        logic [DATA_W-1:0] mz;
        logic [DATA_W-1:0] p;
        mz = DATA_W'(m);
        p  = d * mz;
        return data_t'(p);
    endfunction

endpackage

// File: rtl/flow_pipe.sv
// flow_pipe: enable-gated delay line of depth D and width W with
// synchronous active-high reset.
module flow_pipe #(
    parameter int W = 4,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] pipe_q [D];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < D; s++) pipe_q[s] <= '0;
        end else if (en) begin
            pipe_q[0] <= d_i;
            for (int s = 1; s < D; s++) pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign q_o = pipe_q[D-1];

endmodule

// File: rtl/flow_mult.sv
// flow_mult: N-lane signed x unsigned multiplier, PIPE enabled cycles deep.
// Define FLOW_MULT_DATA_RST_EN to also clear the data stages on reset.
module flow_mult
    import flow_math_pkg::*;
#(
    parameter int N    = 2,
    parameter int PIPE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic [N*MULT_W-1:0] in_mult,
    input  logic                in_sob,
    input  logic                in_eob,
    input  logic                in_sof,
    output logic                out_valid,
    output logic [N*DATA_W-1:0] out_data,
    output logic                out_sob,
    output logic                out_eob,
    output logic                out_sof
);

    logic [N*DATA_W-1:0] prod_d;
    logic [N*DATA_W-1:0] data_q [PIPE];
    logic [3:0]          flags_d;
    logic [3:0]          flags_q;

    always_comb begin
        prod_d = '0;
        for (int i = 0; i < N; i++) begin
            prod_d[i*DATA_W +: DATA_W] = mul_lane(in_data[i*DATA_W +: DATA_W],
                                                  in_mult[i*MULT_W +: MULT_W]);
        end
    end

    // Product is formed in stage 0; later stages only carry it forward.
    always_ff @(posedge clk) begin
`ifdef FLOW_MULT_DATA_RST_EN
        if (rst) begin
            for (int s = 0; s < PIPE; s++) data_q[s] <= '0;
        end else
`endif
        if (en) begin
            data_q[0] <= prod_d;
            for (int s = 1; s < PIPE; s++) data_q[s] <= data_q[s-1];
        end
    end

    assign flags_d = {in_valid, in_sob, in_eob, in_sof};

    flow_pipe #(
        .W (4),
        .D (PIPE)
    ) u_flags (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d_i (flags_d),
        .q_o (flags_q)
    );

    assign out_data  = data_q[PIPE-1];
    assign out_valid = flags_q[3];
    assign out_sob   = flags_q[2];
    assign out_eob   = flags_q[1];
    assign out_sof   = flags_q[0];

endmodule

// File: tb/tb_flow_mult.sv
// tb_flow_mult: directed checks of flow_mult (N=2, PIPE=4): products,
// truncation, sideband alignment, enable stalls and mid-flight reset.
module tb_flow_mult;

    localparam int N    = 2;
    localparam int PIPE = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            in_valid;
    logic [N*16-1:0] in_data;
    logic [N*10-1:0] in_mult;
    logic            in_sob;
    logic            in_eob;
    logic            in_sof;
    logic            out_valid;
    logic [N*16-1:0] out_data;
    logic            out_sob;
    logic            out_eob;
    logic            out_sof;

    int tests = 0;
    int fails = 0;

    flow_mult #(.N(N), .PIPE(PIPE)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_mult   (in_mult),
        .in_sob    (in_sob),
        .in_eob    (in_eob),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sob   (out_sob),
        .out_eob   (out_eob),
        .out_sof   (out_sof)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d0,
                         input logic [9:0] m0, input logic [15:0] d1,
                         input logic [9:0] m1, input logic sob,
                         input logic eob, input logic sof);
        in_valid = v;
        in_data  = {d1, d0};
        in_mult  = {m1, m0};
        in_sob   = sob;
        in_eob   = eob;
        in_sof   = sof;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 10'h0, 16'h0, 10'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int e;
        int b;
        logic [15:0] x0;
        logic [15:0] x1;
        logic pause;

        rst = 1'b1;
        en  = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sob",   32'(out_sob),   32'd0);
        chk("rst_eob",   32'(out_eob),   32'd0);
        chk("rst_sof",   32'(out_sof),   32'd0);
        rst = 1'b0;
        tick();

        // lane0 100*3, lane1 -2*1023
        drive(1'b1, 16'd100, 10'd3, 16'hFFFE, 10'd1023, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk("lat_early", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_lane0", 32'(out_data[15:0]), 32'd300);
        chk("t1_lane1", 32'(out_data[31:16]), 32'hF802);
        chk("t1_sob", 32'(out_sob), 32'd1);
        chk("t1_eob", 32'(out_eob), 32'd0);
        tick();
        chk("t1_gone", 32'(out_valid), 32'd0);

        // truncation on lane0, zero multiplier on lane1
        drive(1'b1, 16'h7FFF, 10'h3FF, 16'd5, 10'd0, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        tick();
        tick();
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_lane0", 32'(out_data[15:0]), 32'h7C01);
        chk("t2_lane1", 32'(out_data[31:16]), 32'h0);
        chk("t2_eob", 32'(out_eob), 32'd1);
        chk("t2_sof", 32'(out_sof), 32'd1);
        for (int k = 0; k < 4; k++) tick();

        // 32-beat block with a 5-cycle enable stall in the middle
        e = 0;
        for (int c = 0; c < 41; c++) begin
            pause = (c >= 12 && c <= 16);
            if (pause) begin
                en = 1'b0;
                drive(1'b1, 16'h1234, 10'h55, 16'h4321, 10'h66,
                      1'b1, 1'b1, 1'b0);
            end else begin
                en = 1'b1;
                if (e < 32)
                    drive(1'b1, 16'(e + 1), 10'd2, 16'(-e), 10'd3,
                          e == 0, e == 31, 1'b1);
                else
                    idle();
            end
            tick();
            if (!pause) e++;
            b = e - PIPE;
            if (b >= 0 && b < 32) begin
                x0 = 16'(2 * b + 2);
                x1 = 16'(-3 * b);
                chk("blk_valid", 32'(out_valid), 32'd1);
                chk("blk_lane0", 32'(out_data[15:0]), 32'(x0));
                chk("blk_lane1", 32'(out_data[31:16]), 32'(x1));
                chk("blk_sob", 32'(out_sob), 32'(b == 0));
                chk("blk_eob", 32'(out_eob), 32'(b == 31));
                chk("blk_sof", 32'(out_sof), 32'd1);
            end else begin
                chk("blk_idle", 32'(out_valid), 32'd0);
            end
        end

        // reset with three beats in flight, asserted while en=0
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'(k + 7), 10'd1, 16'd1, 10'd1, 1'b1, 1'b1, 1'b1);
            tick();
        end
        idle();
        en  = 1'b0;
        rst = 1'b1;
        tick();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 0; k < PIPE; k++) begin
            tick();
            chk("mrst_flush", 32'(out_valid), 32'd0);
            chk("mrst_sob", 32'(out_sob), 32'd0);
        end

        // first beat after reset: -300 * 7
        drive(1'b1, 16'(-300), 10'd7, 16'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();
        chk("post_valid", 32'(out_valid), 32'd1);
        chk("post_lane0", 32'(out_data[15:0]), 32'hF7CC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
